// File: rtl/elevator_scan_ctrl_pkg.sv
// Purpose: shared FSM state and direction encodings for the elevator SCAN controller.
// Contents: state_t (IDLE/MOVE/DOOR), dir_t (DIR_IDLE/DIR_UP/DIR_DN), reverse_dir helper.
// Ports: none (package only).
package elevator_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  // Code 2'b11 is never produced.
  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DN   = 2'b10
  } dir_t;

  function automatic dir_t reverse_dir(input dir_t d);
    case (d)
      DIR_UP:  return DIR_DN;
      DIR_DN:  return DIR_UP;
      default: return DIR_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// Purpose: combinational scan of latched requests relative to one floor.
// Latency: purely combinational; no state, no flow control.
// Ports: pend_car/pend_up/pend_dn latched requests, floor under test, dir travel
//        direction -> any_above/any_below/any_here, stop_here (stop rule for a car
//        arriving at floor while travelling in dir), nearest_up (nearest pending
//        floor is above, ties resolved upward).
module elevator_req_scan
  import elevator_scan_ctrl_pkg::*;
#(
  parameter int NUM_FLOORS = 8,
  parameter int FW         = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pend_car,
  input  logic [NUM_FLOORS-1:0] pend_up,
  input  logic [NUM_FLOORS-1:0] pend_dn,
  input  logic [FW-1:0]         floor,
  input  dir_t                  dir,
  output logic                  any_above,
  output logic                  any_below,
  output logic                  any_here,
  output logic                  stop_here,
  output logic                  nearest_up
);

  logic [NUM_FLOORS-1:0] pend;
  int                    fl;
  int                    best;

  assign pend = pend_car | pend_up | pend_dn;

  always_comb begin
    any_above  = 1'b0;
    any_below  = 1'b0;
    nearest_up = 1'b0;
    best       = NUM_FLOORS;
    fl         = int'(floor);
    // Floors below are visited first with a strict compare; floors above use <=,
    // so an equal-distance floor above wins the tie.
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pend[i]) begin
        if (i > fl) begin
          any_above = 1'b1;
          if (i - fl <= best) begin
            best       = i - fl;
            nearest_up = 1'b1;
          end
        end else if (i < fl) begin
          any_below = 1'b1;
          if (fl - i < best) begin
            best       = fl - i;
            nearest_up = 1'b0;
          end
        end
      end
    end
    any_here = pend[floor];
    // Stop for an in-car request, a hall call matching travel, or end of run.
    case (dir)
      DIR_UP:  stop_here = pend_car[floor] | pend_up[floor] | ~any_above;
      DIR_DN:  stop_here = pend_car[floor] | pend_dn[floor] | ~any_below;
      default: stop_here = any_here;
    endcase
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Purpose: SCAN elevator controller: latches car/hall calls, moves the car floor by
//          floor, opens the door at served floors and reverses at the end of a run.
// Latency: request -> pending next cycle; idle car starts moving one cycle later.
// Ports: clk, rst (sync, active-high); hall_up/hall_dn/car_req per-floor calls;
//        door_hold; current_floor, direction, moving, door_open, pending.
module elevator_scan_ctrl
  import elevator_scan_ctrl_pkg::*;
#(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_FLOORS-1:0]         hall_up,
  input  logic [NUM_FLOORS-1:0]         hall_dn,
  input  logic [NUM_FLOORS-1:0]         car_req,
  input  logic                          door_hold,
  output logic [$clog2(NUM_FLOORS)-1:0] current_floor,
  output logic [1:0]                    direction,
  output logic                          moving,
  output logic                          door_open,
  output logic [NUM_FLOORS-1:0]         pending
);

  localparam int FW  = $clog2(NUM_FLOORS);
  localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TCW-1:0]        TRAVEL_LAST = TCW'(TRAVEL_CYCLES - 1);
  localparam logic [DCW-1:0]        DOOR_LAST   = DCW'(DOOR_CYCLES - 1);
  localparam logic [NUM_FLOORS-1:0] ONE         = NUM_FLOORS'(1);
  // No up call from the top floor, no down call from floor 0.
  localparam logic [NUM_FLOORS-1:0] UP_OK       = ~(ONE << (NUM_FLOORS - 1));
  localparam logic [NUM_FLOORS-1:0] DN_OK       = ~ONE;

  state_t                state;
  dir_t                  dir;
  logic [FW-1:0]         floor;
  logic [TCW-1:0]        tcnt;
  logic [DCW-1:0]        dcnt;
  logic [NUM_FLOORS-1:0] pend_car, pend_up, pend_dn;

  logic                  tick, beyond, behind, door_req;
  logic                  any_above, any_below, any_here, stop_here, nearest_up;
  logic [FW-1:0]         next_floor, scan_floor;
  logic [NUM_FLOORS-1:0] here, up_in, dn_in, serve, clr_car, clr_up, clr_dn;

  assign current_floor = floor;
  assign direction     = dir;
  assign pending       = pend_car | pend_up | pend_dn;

  assign up_in      = hall_up & UP_OK;
  assign dn_in      = hall_dn & DN_OK;
  assign tick       = (state == MOVE) && (tcnt == TRAVEL_LAST);
  assign next_floor = (dir == DIR_UP) ? floor + FW'(1) : floor - FW'(1);
  // On the arrival cycle the scan looks at the floor being entered, so the stop
  // decision and the request clears land on the same edge as the floor update.
  assign scan_floor = tick ? next_floor : floor;
  assign here       = ONE << scan_floor;
  assign beyond     = ((dir == DIR_UP) && any_above) || ((dir == DIR_DN) && any_below);
  assign behind     = ((dir == DIR_UP) && any_below) || ((dir == DIR_DN) && any_above);
  assign door_req   = |((car_req | up_in | dn_in) & here);

  elevator_req_scan #(
    .NUM_FLOORS (NUM_FLOORS),
    .FW         (FW)
  ) u_scan (
    .pend_car   (pend_car),
    .pend_up    (pend_up),
    .pend_dn    (pend_dn),
    .floor      (scan_floor),
    .dir        (dir),
    .any_above  (any_above),
    .any_below  (any_below),
    .any_here   (any_here),
    .stop_here  (stop_here),
    .nearest_up (nearest_up)
  );

  // Requests served on this edge; a clear beats a simultaneous new request.
  always_comb begin
    clr_car = '0;
    clr_up  = '0;
    clr_dn  = '0;
    serve   = '0;
    case (state)
      IDLE: begin
        if (any_here) begin
          clr_car = here;
          clr_up  = here;
          clr_dn  = here;
        end
      end
      MOVE: begin
        if (tick && stop_here) begin
          clr_car = here;
          if (dir == DIR_UP) clr_up = here;
          else               clr_dn = here;
          // End of run: the opposite call is picked up as the car turns round.
          if (!beyond) begin
            clr_up = here;
            clr_dn = here;
          end
        end
      end
      DOOR:    serve = here;
      default: serve = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= DIR_IDLE;
      floor     <= '0;
      tcnt      <= '0;
      dcnt      <= '0;
      moving    <= 1'b0;
      door_open <= 1'b0;
      pend_car  <= '0;
      pend_up   <= '0;
      pend_dn   <= '0;
    end else begin
      pend_car <= (pend_car | (car_req & ~serve)) & ~clr_car;
      pend_up  <= (pend_up  | (up_in   & ~serve)) & ~clr_up;
      pend_dn  <= (pend_dn  | (dn_in   & ~serve)) & ~clr_dn;
      case (state)
        IDLE: begin
          if (any_here) begin
            state     <= DOOR;
            door_open <= 1'b1;
            dcnt      <= '0;
          end else if (|pending) begin
            state  <= MOVE;
            moving <= 1'b1;
            tcnt   <= '0;
            dir    <= nearest_up ? DIR_UP : DIR_DN;
          end else begin
            dir <= DIR_IDLE;
          end
        end
        MOVE: begin
          if (tick) begin
            tcnt  <= '0;
            floor <= next_floor;
            if (stop_here) begin
              state     <= DOOR;
              moving    <= 1'b0;
              door_open <= 1'b1;
              dcnt      <= '0;
              if (!beyond) dir <= reverse_dir(dir);
            end
          end else begin
            tcnt <= tcnt + TCW'(1);
          end
        end
        DOOR: begin
          if (door_hold || door_req) begin
            dcnt <= '0;
          end else if (dcnt == DOOR_LAST) begin
            dcnt      <= '0;
            door_open <= 1'b0;
            if (beyond) begin
              state  <= MOVE;
              moving <= 1'b1;
              tcnt   <= '0;
            end else if (behind) begin
              state  <= MOVE;
              moving <= 1'b1;
              tcnt   <= '0;
              dir    <= reverse_dir(dir);
            end else begin
              state <= IDLE;
              dir   <= DIR_IDLE;
            end
          end else begin
            dcnt <= dcnt + DCW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          moving    <= 1'b0;
          door_open <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Purpose: self-checking bench for elevator_scan_ctrl (4 floors, 4 travel, 6 door cycles).
// Reference: floor-level behavioural model using integer floor/direction and request arrays.
// Ports: none (top-level bench).
module tb_elevator_scan_ctrl;

  localparam int N = 4;
  localparam int T = 4;
  localparam int D = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] hall_up, hall_dn, car_req;
  logic         door_hold;
  logic [1:0]   current_floor;
  logic [1:0]   direction;
  logic         moving, door_open;
  logic [N-1:0] pending;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: mode 0 idle, 1 travelling, 2 door open; dir -1/0/+1.
  int m_floor, m_dir, m_mode, m_tc, m_dc;
  bit m_car[N], m_up[N], m_dn[N];

  elevator_scan_ctrl #(
    .NUM_FLOORS    (N),
    .TRAVEL_CYCLES (T),
    .DOOR_CYCLES   (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .hall_up       (hall_up),
    .hall_dn       (hall_dn),
    .car_req       (car_req),
    .door_hold     (door_hold),
    .current_floor (current_floor),
    .direction     (direction),
    .moving        (moving),
    .door_open     (door_open),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  function automatic bit pend_at(int f);
    return m_car[f] || m_up[f] || m_dn[f];
  endfunction

  function automatic bit beyond(int f, int d);
    for (int g = 0; g < N; g++)
      if ((g - f) * d > 0 && pend_at(g)) return 1'b1;
    return 1'b0;
  endfunction

  // Search outward from the car; the floor above is tried first at each distance.
  function automatic int nearest_dir();
    for (int d = 1; d < N; d++) begin
      if (m_floor + d <= N - 1 && pend_at(m_floor + d)) return 1;
      if (m_floor - d >= 0 && pend_at(m_floor - d)) return -1;
    end
    return 0;
  endfunction

  function automatic logic [9:0] m_out();
    logic [1:0] d;
    logic [3:0] p;
    d = (m_dir == 1) ? 2'b01 : (m_dir == -1) ? 2'b10 : 2'b00;
    for (int f = 0; f < N; f++) p[f] = m_car[f] | m_up[f] | m_dn[f];
    return {2'(m_floor), d, m_mode == 1, m_mode == 2, p};
  endfunction

  task automatic m_step();
    bit c_car[N], c_up[N], c_dn[N], s[N];
    bit any, far;
    int nf;
    if (rst) begin
      m_floor = 0; m_dir = 0; m_mode = 0; m_tc = 0; m_dc = 0;
      for (int f = 0; f < N; f++) begin m_car[f] = 0; m_up[f] = 0; m_dn[f] = 0; end
      return;
    end
    any = 0;
    for (int f = 0; f < N; f++) begin
      c_car[f] = 0; c_up[f] = 0; c_dn[f] = 0; s[f] = 0;
      if (pend_at(f)) any = 1;
    end
    case (m_mode)
      0: begin
        if (!any) m_dir = 0;
        else if (pend_at(m_floor)) begin
          m_mode = 2; m_dc = 0;
          c_car[m_floor] = 1; c_up[m_floor] = 1; c_dn[m_floor] = 1;
        end else begin
          m_dir = nearest_dir(); m_mode = 1; m_tc = 0;
        end
      end
      1: begin
        if (m_tc == T - 1) begin
          m_tc = 0;
          nf = m_floor + m_dir;
          far = beyond(nf, m_dir);
          if (m_car[nf] || (m_dir == 1 && m_up[nf]) || (m_dir == -1 && m_dn[nf]) || !far) begin
            m_mode = 2; m_dc = 0;
            c_car[nf] = 1;
            if (m_dir == 1) c_up[nf] = 1; else c_dn[nf] = 1;
            if (!far) begin c_up[nf] = 1; c_dn[nf] = 1; m_dir = -m_dir; end
          end
          m_floor = nf;
        end else m_tc++;
      end
      default: begin
        s[m_floor] = 1;
        if (door_hold || car_req[m_floor] || (hall_up[m_floor] && m_floor != N - 1) ||
            (hall_dn[m_floor] && m_floor != 0)) m_dc = 0;
        else if (m_dc == D - 1) begin
          if (m_dir != 0 && beyond(m_floor, m_dir)) begin m_mode = 1; m_tc = 0; end
          else if (m_dir != 0 && beyond(m_floor, -m_dir)) begin m_mode = 1; m_tc = 0; m_dir = -m_dir; end
          else begin m_mode = 0; m_dir = 0; end
        end else m_dc++;
      end
    endcase
    for (int f = 0; f < N; f++) begin
      m_car[f] = (m_car[f] || (car_req[f] && !s[f])) && !c_car[f];
      m_up[f]  = (m_up[f] || (hall_up[f] && f != N - 1 && !s[f])) && !c_up[f];
      m_dn[f]  = (m_dn[f] || (hall_dn[f] && f != 0 && !s[f])) && !c_dn[f];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic clear_inputs();
    hall_up = '0; hall_dn = '0; car_req = '0; door_hold = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    if ({current_floor, direction, moving, door_open, pending} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_values got %b want %b", {current_floor, direction, moving, door_open, pending}, 10'b0);
    end
    n_vec++;
    if ({current_floor, direction, moving, door_open, pending} !== m_out()) begin
      n_bad++;
      $display("FAIL reset_model got %b want %b", {current_floor, direction, moving, door_open, pending}, m_out());
    end
    n_vec++;
    rst = 1'b0;
  endtask

  task automatic test_single_trip();
    int mv_at, f1_at, f2_at, door_n;
    do_reset();
    car_req = 4'b0100;
    tick();
    car_req = '0;
    if (pending !== 4'b0100) begin
      n_bad++;
      $display("FAIL trip_pending got %b want %b", pending, 4'b0100);
    end
    n_vec++;
    mv_at = -1; f1_at = -1; f2_at = -1; door_n = 0;
    for (int k = 2; k <= 30; k++) begin
      tick();
      if ({current_floor, direction, moving, door_open, pending} !== m_out()) begin
        n_bad++;
        $display("FAIL trip k=%0d got %b want %b", k, {current_floor, direction, moving, door_open, pending}, m_out());
      end
      n_vec++;
      if (moving && mv_at < 0) mv_at = k;
      if (current_floor == 2'd1 && f1_at < 0) f1_at = k;
      if (current_floor == 2'd2 && f2_at < 0) f2_at = k;
      if (door_open) door_n++;
    end
    if (mv_at != 2 || f1_at != 6 || f2_at != 10 || door_n != 6) begin
      n_bad++;
      $display("FAIL trip_timing got mv=%0d f1=%0d f2=%0d door=%0d want 2 6 10 6", mv_at, f1_at, f2_at, door_n);
    end
    n_vec++;
    if ({current_floor, direction, moving, door_open, pending} !== 10'b10_00_0_0_0000) begin
      n_bad++;
      $display("FAIL trip_end got %b want %b", {current_floor, direction, moving, door_open, pending}, 10'b10_00_0_0_0000);
    end
    n_vec++;
  endtask

  task automatic test_hall_scan();
    int stops[$];
    logic [1:0] dirs[$];
    logic prev;
    do_reset();
    car_req = 4'b1000; hall_dn = 4'b0010; hall_up = 4'b0100;
    tick();
    clear_inputs();
    prev = 1'b0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if ({current_floor, direction, moving, door_open, pending} !== m_out()) begin
        n_bad++;
        $display("FAIL scan k=%0d got %b want %b", k, {current_floor, direction, moving, door_open, pending}, m_out());
      end
      n_vec++;
      if (door_open && !prev) begin
        stops.push_back(int'(current_floor));
        dirs.push_back(direction);
      end
      prev = door_open;
    end
    if (stops.size() != 3 || stops[0] != 2 || stops[1] != 3 || stops[2] != 1) begin
      n_bad++;
      $display("FAIL scan_stops got n=%0d %0d,%0d,%0d want n=3 2,3,1", stops.size(), stops[0], stops[1], stops[2]);
    end
    n_vec++;
    if (dirs.size() != 3 || dirs[1] !== 2'b10) begin
      n_bad++;
      $display("FAIL scan_reverse got %b want 10", dirs[1]);
    end
    n_vec++;
  endtask

  task automatic test_door_hold();
    int door_first, door_n;
    bit moved, left0;
    do_reset();
    car_req = 4'b0001;
    tick();
    car_req = '0;
    door_first = -1; door_n = 0; moved = 0; left0 = 0;
    for (int k = 1; k <= 30; k++) begin
      door_hold = (k >= 2 && k <= 11);
      tick();
      if ({current_floor, direction, moving, door_open, pending} !== m_out()) begin
        n_bad++;
        $display("FAIL hold k=%0d got %b want %b", k + 1, {current_floor, direction, moving, door_open, pending}, m_out());
      end
      n_vec++;
      if (door_open && door_first < 0) door_first = k + 1;
      if (door_open) door_n++;
      if (moving) moved = 1;
      if (current_floor != 2'd0) left0 = 1;
    end
    door_hold = 1'b0;
    if (door_first != 2 || door_n != 16 || moved || left0) begin
      n_bad++;
      $display("FAIL hold_door got first=%0d len=%0d moved=%0d left=%0d want 2 16 0 0", door_first, door_n, moved, left0);
    end
    n_vec++;
  endtask

  task automatic test_tie();
    int stops[$];
    logic prev;
    do_reset();
    car_req = 4'b0100;
    tick();
    car_req = '0;
    for (int k = 0; k < 40; k++) tick();
    if (current_floor !== 2'd2 || moving !== 1'b0 || door_open !== 1'b0) begin
      n_bad++;
      $display("FAIL tie_park got floor=%0d mv=%b door=%b want 2 0 0", current_floor, moving, door_open);
    end
    n_vec++;
    car_req = 4'b1010;
    tick();
    car_req = '0;
    prev = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if ({current_floor, direction, moving, door_open, pending} !== m_out()) begin
        n_bad++;
        $display("FAIL tie k=%0d got %b want %b", k, {current_floor, direction, moving, door_open, pending}, m_out());
      end
      n_vec++;
      if (door_open && !prev) stops.push_back(int'(current_floor));
      prev = door_open;
    end
    if (stops.size() != 2 || stops[0] != 3 || stops[1] != 1) begin
      n_bad++;
      $display("FAIL tie_order got n=%0d %0d,%0d want n=2 3,1", stops.size(), stops[0], stops[1]);
    end
    n_vec++;
  endtask

  task automatic test_ignored();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      hall_dn = (k < 3) ? 4'b0001 : 4'b0000;
      hall_up = (k < 3) ? 4'b1000 : 4'b0000;
      tick();
      if (pending !== 4'b0000 || moving !== 1'b0 || door_open !== 1'b0) begin
        n_bad++;
        $display("FAIL ignored k=%0d got pend=%b mv=%b door=%b want 0000 0 0", k, pending, moving, door_open);
      end
      n_vec++;
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_move();
    bit reached;
    do_reset();
    car_req = 4'b1000;
    tick();
    car_req = '0;
    reached = 0;
    for (int k = 0; k < 40 && !reached; k++) begin
      tick();
      if (current_floor == 2'd1) reached = 1;
    end
    if (!reached) begin
      n_bad++;
      $display("FAIL midmove_timeout got floor=%0d want 1", current_floor);
    end
    n_vec++;
    tick();
    tick();
    if (moving !== 1'b1 || current_floor !== 2'd1) begin
      n_bad++;
      $display("FAIL midmove_state got mv=%b floor=%0d want 1 1", moving, current_floor);
    end
    n_vec++;
    rst = 1'b1;
    tick();
    if ({current_floor, direction, moving, door_open, pending} !== 10'b0) begin
      n_bad++;
      $display("FAIL midmove_reset got %b want %b", {current_floor, direction, moving, door_open, pending}, 10'b0);
    end
    n_vec++;
    rst = 1'b0;
    tick();
    if ({current_floor, direction, moving, door_open, pending} !== 10'b0) begin
      n_bad++;
      $display("FAIL midmove_after got %b want %b", {current_floor, direction, moving, door_open, pending}, 10'b0);
    end
    n_vec++;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      for (int f = 0; f < N; f++) begin
        car_req[f] = ($urandom_range(0, 15) == 0);
        hall_up[f] = ($urandom_range(0, 19) == 0);
        hall_dn[f] = ($urandom_range(0, 19) == 0);
      end
      door_hold = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
      if ({current_floor, direction, moving, door_open, pending} !== m_out()) begin
        n_bad++;
        $display("FAIL random k=%0d got %b want %b", k, {current_floor, direction, moving, door_open, pending}, m_out());
      end
      n_vec++;
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_single_trip();
    test_hall_scan();
    test_door_hold();
    test_tie();
    test_ignored();
    test_reset_mid_move();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/elevator_scan_ctrl.md
ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 8, number of floors (>=2); FW = clog2(NUM_FLOORS).
REQ-002 SHALL have parameter TRAVEL_CYCLES, default 4, clock cycles to move one floor (>=1).
REQ-003 SHALL have parameter DOOR_CYCLES, default 6, clock cycles door stays open (>=1).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 hall_up  input  NUM_FLOORS  per-floor up call pulse/level; bit NUM_FLOORS-1 ignored.
REQ-007 hall_dn  input  NUM_FLOORS  per-floor down call; bit 0 ignored.
REQ-008 car_req  input  NUM_FLOORS  in-car floor request.
REQ-009 door_hold  input  1  while high in DOOR, door timer reloads.
REQ-010 current_floor  output  FW  floor index of car.
REQ-011 direction  output  2  00 idle, 01 up, 10 down; 11 never driven.
REQ-012 moving  output  1  high only in MOVE state.
REQ-013 door_open  output  1  high only in DOOR state.
REQ-014 pending  output  NUM_FLOORS  OR of latched car/up/down requests per floor.

Function
REQ-015 SHALL latch each request bit into pend_car/pend_up/pend_dn one cycle after input high; bits stay set until served.
REQ-016 SHALL implement FSM states IDLE, MOVE, DOOR.
REQ-017 IDLE: no pending -> stay, direction=00; pending at current floor -> DOOR next cycle; else direction toward nearest pending floor (tie: up) and MOVE next cycle.
REQ-018 MOVE: travel counter counts TRAVEL_CYCLES cycles, then current_floor +/-1 per direction; counter reloads.
REQ-019 On floor update, stop (-> DOOR) if pend_car[f], or hall call at f in travel direction, or no pending beyond f in travel direction; else continue MOVE.
REQ-020 Entering DOOR at f SHALL clear pend_car[f] and hall call at f in travel direction; opposite hall call at f also cleared if no pending beyond f in travel direction, with direction reversing.
REQ-021 DOOR: door timer counts DOOR_CYCLES; door_hold or new request for f (any type) reloads timer and request is served (not latched).
REQ-022 DOOR timeout: pending beyond f in direction -> MOVE same direction; else pending opposite -> MOVE reversed; else IDLE, direction=00.
REQ-023 current_floor SHALL never leave 0..NUM_FLOORS-1; at floor 0 direction never 10, at top never 01.
REQ-024 Request set and clear for same bit in same cycle: clear wins (request considered served).
REQ-025 Latency: request at idle car, other floor, cycle t -> pending at t+1, moving at t+2.
REQ-026 Ignored bits (hall_up top, hall_dn floor 0) SHALL never set pending.

Reset
REQ-027 rst SHALL force IDLE, current_floor=0, direction=00, moving=0, door_open=0, all pending cleared, both counters cleared, taking priority over all inputs.
REQ-028 rst mid-MOVE or mid-DOOR SHALL abandon operation; car reported at floor 0 next cycle.

Structure
REQ-029 Shared package SHALL hold state encoding (IDLE/MOVE/DOOR) and direction codes (DIR_IDLE/DIR_UP/DIR_DN).
REQ-030 One sub-module elevator_req_scan SHALL compute combinationally any_above, any_below, stop_here from pending vectors and current_floor.
REQ-031 Display/seven-segment decoding SHALL stay outside this block.

Verification (NUM_FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=6)
REQ-032 Reset, car_req[2] pulse -> moving at t+2, current_floor 1 then 2 at 4-cycle steps, door_open 6 cycles, then IDLE, pending=0.
REQ-033 Car moving up 0->3 with car_req[3]; hall_dn[1] and hall_up[2] pulsed early -> stops at 2 only, then 3, then reverses, stops at 1.
REQ-034 Idle at 0, car_req[0] -> door_open at t+2, no movement, door_hold held 10 cycles extends door to 16 cycles.
REQ-035 car_req[3] and car_req[1] same cycle at floor 2 idle -> tie goes up: serves 3 then 1.
REQ-036 hall_dn[0] and hall_up[3] pulsed -> pending stays 0, car idle.
REQ-037 rst asserted mid-MOVE between floors 1 and 2 -> next cycle floor 0, IDLE, all outputs at reset values.
